if_fetch_stage: RTL
===================

Name: if_fetch_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS-style pipeline. Owns the program counter, drives the word-addressed combinational instruction memory, and captures the returned instruction into the IF/ID pipeline register. Honours stall requests from the hazard unit and branch/jump redirects resolved in ID, squashing the wrong-path instruction. Exposes fetch/squash event counters for bring-up debug.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; low 2 bits must be 0
XLEN, 32, datapath width of PC and instruction
CNT_W, 32, width of the debug event counters

Ports:
clk  input  1  pipeline clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
stall  input  1  hazard unit: hold PC and IF/ID contents this cycle
redirect  input  1  ID stage: taken branch or jump, PC must change
redirect_pc  input  XLEN  target address for redirect
imem_addr  output  XLEN  byte address to instruction memory (equals pc)
imem_rdata  input  XLEN  instruction returned combinationally for imem_addr
pc  output  XLEN  current fetch PC
if_id_instr  output  XLEN  registered instruction for ID
if_id_pc4  output  XLEN  registered PC+4 of that instruction (branch base)
if_id_valid  output  1  1 = if_id_instr is a real instruction; 0 = bubble
fetch_count  output  CNT_W  number of instructions accepted into IF/ID
squash_count  output  CNT_W  number of redirects taken

Behaviour:
- Reset (reset=1 at posedge, regardless of stall/redirect): pc<=RESET_PC; if_id_instr<=32'h0 (NOP); if_id_pc4<=0; if_id_valid<=0; both counters<=0.
- imem_addr = pc, combinational. Memory indexes pc[9:2]; this stage never touches low bits beyond alignment.
- Per-posedge priority when not in reset: redirect > stall > advance.
- Advance (redirect=0, stall=0): pc<=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC->0); if_id_instr<=imem_rdata; if_id_pc4<=pc+4; if_id_valid<=1; fetch_count+=1.
- Stall (redirect=0, stall=1): pc, if_id_instr, if_id_pc4, if_id_valid all hold; counters hold.
- Redirect (redirect=1, stall ignored): pc<={redirect_pc[31:2],2'b00}; if_id_instr<=NOP; if_id_pc4<=0; if_id_valid<=0; squash_count+=1; fetch_count holds. Misaligned target bits silently cleared.
- Latency: instruction at address A is present in IF/ID one cycle after pc==A with no stall/redirect at that edge. Redirect penalty: exactly 1 bubble.
- First cycle after reset release: pc==RESET_PC; IF/ID holds a bubble until first advance edge.
- Back-to-back redirects: each one reloads pc and inserts a bubble; squash_count increments every cycle redirect=1.
- Reset mid-stall or mid-redirect: reset wins; no partial update.
- Counters wrap at 2^CNT_W, no saturation.
- No X propagation: if_id_* never loads imem_rdata during stall or redirect.

Decomposition:
- Shared package pipeline_pkg: NOP_INSTR (32'h0), RESET_PC default, XLEN, opcode constants (OP_RTYPE 6'b000000, OP_LW 6'b100011, OP_SW 6'b101011, OP_BEQ 6'b000100) used by ID and hazard unit.
- One sub-module: if_id_reg (instr/pc4/valid register with hold and flush inputs, reset to bubble); PC and counters stay in the top.

Test Plan:
- Reset then free-run, mem[3]=32'h8C01_0000: pc steps 0,4,8,12; one cycle after pc==12 if_id_instr==32'h8C01_0000, if_id_pc4==16, valid=1; fetch_count==4.
- Stall for 3 cycles while pc==16: pc stays 16, IF/ID unchanged, fetch_count unchanged; on release pc==20 next edge.
- Redirect with redirect_pc=32'h0000_000C while pc==48: next pc==12, if_id_valid=0, if_id_instr==0, squash_count==1; following edge if_id_instr==mem[3].
- Redirect and stall asserted together, redirect_pc=32'h22: pc==32'h20 (aligned), bubble inserted, stall ignored.
- Reset asserted during a stall with pc==40: next edge pc==0, if_id_valid=0, both counters==0.
- pc forced near wrap via redirect_pc=32'hFFFF_FFFC then advance: pc==0, if_id_pc4==0, valid=1.

Source files
------------

// File: rtl/pipeline_pkg.sv
// ============================================================================
// Module   : pipeline_pkg
// Brief    : Shared constants for the 5-stage MIPS-style pipeline.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  // Forces a byte address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// ============================================================================
// Module   : if_id_reg
// Brief    : IF/ID pipeline register with hold and flush; resets to a bubble.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_reg
  import pipeline_pkg::*;
#(
  parameter int XLEN = pipeline_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            hold,
  input  logic            flush,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc4_in,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc4,
  output logic            valid
);

  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc4;
  logic            r_valid;

  // Flush outranks hold so a redirect always squashes the wrong-path slot.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_instr <= XLEN'(NOP_INSTR);
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else if (!hold) begin
      r_instr <= instr_in;
      r_pc4   <= pc4_in;
      r_valid <= 1'b1;
    end
  end

  assign instr = r_instr;
  assign pc4   = r_pc4;
  assign valid = r_valid;

endmodule

`default_nettype wire

// File: rtl/if_fetch_stage.sv
// ============================================================================
// Module   : if_fetch_stage
// Brief    : Instruction fetch: PC, imem addressing, IF/ID capture, debug counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = pipeline_pkg::RESET_PC,
  parameter int          XLEN     = pipeline_pkg::XLEN,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [XLEN-1:0]  imem_rdata,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  if_id_instr,
  output logic [XLEN-1:0]  if_id_pc4,
  output logic             if_id_valid,
  output logic [CNT_W-1:0] fetch_count,
  output logic [CNT_W-1:0] squash_count
);

  logic [XLEN-1:0]  r_pc;
  logic [CNT_W-1:0] r_fetch_count;
  logic [CNT_W-1:0] r_squash_count;
  logic [XLEN-1:0]  w_pc4;
  logic [XLEN-1:0]  w_target;
  logic             w_advance;

  assign w_pc4     = r_pc + XLEN'(4);
  assign w_target  = {redirect_pc[XLEN-1:2], 2'b00};
  assign w_advance = !redirect && !stall;

  // Priority: reset > redirect > stall > advance. Counters wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc           <= XLEN'(RESET_PC);
      r_fetch_count  <= '0;
      r_squash_count <= '0;
    end else if (redirect) begin
      r_pc           <= w_target;
      r_squash_count <= r_squash_count + CNT_W'(1);
    end else if (!stall) begin
      r_pc           <= w_pc4;
      r_fetch_count  <= r_fetch_count + CNT_W'(1);
    end
  end

  if_id_reg #(
    .XLEN (XLEN)
  ) u_if_id_reg (
    .clk      (clk),
    .reset    (reset),
    .hold     (!w_advance),
    .flush    (redirect),
    .instr_in (imem_rdata),
    .pc4_in   (w_pc4),
    .instr    (if_id_instr),
    .pc4      (if_id_pc4),
    .valid    (if_id_valid)
  );

  assign imem_addr    = r_pc;
  assign pc           = r_pc;
  assign fetch_count  = r_fetch_count;
  assign squash_count = r_squash_count;

endmodule

`default_nettype wire
